// File: rtl/ball_pkg.sv
// rtl/ball_pkg.sv - shared keycodes, screen geometry and motion type for the ball controller
package ball_pkg;

   localparam logic [7:0] KEY_W = 8'h1A;
   localparam logic [7:0] KEY_A = 8'h04;
   localparam logic [7:0] KEY_S = 8'h16;
   localparam logic [7:0] KEY_D = 8'h07;

   localparam int BALL_X_CENTER = 320;
   localparam int BALL_Y_CENTER = 240;
   localparam int BALL_X_MIN    = 0;
   localparam int BALL_X_MAX    = 639;
   localparam int BALL_Y_MIN    = 0;
   localparam int BALL_Y_MAX    = 479;
   localparam int BALL_STEP     = 1;
   localparam int BALL_SIZE     = 4;

   typedef logic signed [9:0] motion_t;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - single-clock 0->1 detector for a per-frame strobe
module rise_detect (
   input  logic Clk,
   input  logic Reset,
   input  logic in,
   output logic rise
);

   logic in_q;
   logic in_d;

   always_comb begin
      in_d = in;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         in_q <= 1'b0;
      end else begin
         in_q <= in_d;
      end
   end

   // Cleared history at release means a strobe already high counts as a fresh rise.
   assign rise = in & ~in_q;

endmodule

// File: rtl/ball_motion.sv
// rtl/ball_motion.sv - per-frame ball motion with wall bounce and per-pixel ball hit test
import ball_pkg::*;

module ball_motion #(
   parameter int X_CENTER = BALL_X_CENTER,
   parameter int Y_CENTER = BALL_Y_CENTER,
   parameter int X_MIN    = BALL_X_MIN,
   parameter int X_MAX    = BALL_X_MAX,
   parameter int Y_MIN    = BALL_Y_MIN,
   parameter int Y_MAX    = BALL_Y_MAX,
   parameter int STEP     = BALL_STEP,
   parameter int SIZE     = BALL_SIZE
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic [7:0] keycode,
   input  logic [9:0] DrawX,
   input  logic [9:0] DrawY,
   output logic       is_ball,
   output logic [9:0] BallX,
   output logic [9:0] BallY
);

   localparam motion_t            MOTION_POS = motion_t'(STEP);
   localparam motion_t            MOTION_NEG = motion_t'(-STEP);
   localparam logic signed [22:0] RADIUS_SQ  = 23'(SIZE * SIZE);

   logic       frame_rise;
   logic [9:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
   motion_t    motion_x_q, motion_x_d, motion_y_q, motion_y_d;
   motion_t    motion_x_sel, motion_y_sel;
   logic       x_at_max, x_at_min, y_at_max, y_at_min;

   logic signed [10:0] dist_x, dist_y;
   logic signed [21:0] dist_x_ext, dist_y_ext;
   logic signed [21:0] sq_x, sq_y;
   logic signed [22:0] dist_sq;

   rise_detect u_frame_rise (
      .Clk   (Clk),
      .Reset (Reset),
      .in    (frame_clk),
      .rise  (frame_rise)
   );

   always_comb begin
      x_at_max = ({1'b0, ball_x_q} + 11'(SIZE)) >= 11'(X_MAX);
      x_at_min = {1'b0, ball_x_q} <= 11'(X_MIN + SIZE);
      y_at_max = ({1'b0, ball_y_q} + 11'(SIZE)) >= 11'(Y_MAX);
      y_at_min = {1'b0, ball_y_q} <= 11'(Y_MIN + SIZE);

      motion_x_sel = motion_x_q;
      motion_y_sel = motion_y_q;
      case (keycode)
         KEY_W: begin
            motion_y_sel = MOTION_NEG;
            motion_x_sel = '0;
         end
         KEY_S: begin
            motion_y_sel = MOTION_POS;
            motion_x_sel = '0;
         end
         KEY_A: begin
            motion_x_sel = MOTION_NEG;
            motion_y_sel = '0;
         end
         KEY_D: begin
            motion_x_sel = MOTION_POS;
            motion_y_sel = '0;
         end
         default: ;
      endcase

      // A wall only overrides its own axis, so a key's zeroing of the other axis survives.
      if (x_at_max) begin
         motion_x_sel = MOTION_NEG;
      end else if (x_at_min) begin
         motion_x_sel = MOTION_POS;
      end
      if (y_at_max) begin
         motion_y_sel = MOTION_NEG;
      end else if (y_at_min) begin
         motion_y_sel = MOTION_POS;
      end

      motion_x_d = motion_x_q;
      motion_y_d = motion_y_q;
      ball_x_d   = ball_x_q;
      ball_y_d   = ball_y_q;
      if (frame_rise) begin
         motion_x_d = motion_x_sel;
         motion_y_d = motion_y_sel;
         ball_x_d   = ball_x_q + $unsigned(motion_x_sel);
         ball_y_d   = ball_y_q + $unsigned(motion_y_sel);
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         ball_x_q   <= 10'(X_CENTER);
         ball_y_q   <= 10'(Y_CENTER);
         motion_x_q <= '0;
         motion_y_q <= '0;
      end else begin
         ball_x_q   <= ball_x_d;
         ball_y_q   <= ball_y_d;
         motion_x_q <= motion_x_d;
         motion_y_q <= motion_y_d;
      end
   end

   always_comb begin
      dist_x     = $signed({1'b0, DrawX}) - $signed({1'b0, ball_x_q});
      dist_y     = $signed({1'b0, DrawY}) - $signed({1'b0, ball_y_q});
      dist_x_ext = 22'(dist_x);
      dist_y_ext = 22'(dist_y);
      sq_x       = dist_x_ext * dist_x_ext;
      sq_y       = dist_y_ext * dist_y_ext;
      dist_sq    = 23'(sq_x) + 23'(sq_y);
      is_ball    = dist_sq <= RADIUS_SQ;
   end

   assign BallX = ball_x_q;
   assign BallY = ball_y_q;

endmodule

// File: tb/tb_ball_motion.sv
// tb/tb_ball_motion.sv - randomized scoreboard bench for ball_motion against a reference model
module tb_ball_motion;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       frame_clk;
   logic [7:0] keycode;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
   logic       is_ball;
   logic [9:0] BallX;
   logic [9:0] BallY;

   ball_motion dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .frame_clk (frame_clk),
      .keycode   (keycode),
      .DrawX     (DrawX),
      .DrawY     (DrawY),
      .is_ball   (is_ball),
      .BallX     (BallX),
      .BallY     (BallY)
   );

   always #5 Clk = ~Clk;

   typedef struct {int x; int y;} pos_t;
   typedef struct {int dx; int dy; int hit;} probe_t;

   pos_t   pos_q[$];
   probe_t ib_q[$];

   int n_cmp = 0;
   int n_bad = 0;

   int m_bx, m_by, m_mx, m_my;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_bx = 320; m_by = 240; m_mx = 0; m_my = 0;
   endfunction

   // Key intent first, then each wall forces its own axis inward.
   function automatic void model_frame(input logic [7:0] k);
      int nx, ny;
      nx = m_mx; ny = m_my;
      if (k == 8'h04) begin nx = -1; ny = 0; end
      if (k == 8'h07) begin nx = 1;  ny = 0; end
      if (k == 8'h1A) begin ny = -1; nx = 0; end
      if (k == 8'h16) begin ny = 1;  nx = 0; end
      if (m_bx + 4 >= 639) nx = -1;
      else if (m_bx <= 4) nx = 1;
      if (m_by + 4 >= 479) ny = -1;
      else if (m_by <= 4) ny = 1;
      m_mx = nx; m_my = ny;
      m_bx = (m_bx + nx) & 1023;
      m_by = (m_by + ny) & 1023;
   endfunction

   function automatic int model_hit(input int dx, input int dy);
      int ex, ey;
      ex = dx - m_bx;
      ey = dy - m_by;
      return (ex * ex + ey * ey <= 16) ? 1 : 0;
   endfunction

   task automatic frame(input int hold, input int gap);
      pos_t p;
      @(posedge Clk); #1;
      model_frame(keycode);
      p.x = m_bx; p.y = m_by;
      pos_q.push_back(p);
      frame_clk = 1'b1;
      repeat (hold) @(posedge Clk);
      #1 frame_clk = 1'b0;
      repeat (gap) @(posedge Clk);
   endtask

   task automatic probe(input int dx, input int dy);
      probe_t e;
      @(posedge Clk); #1;
      e.dx = dx & 1023; e.dy = dy & 1023;
      e.hit = model_hit(e.dx, e.dy);
      DrawX = e.dx[9:0]; DrawY = e.dy[9:0];
      ib_q.push_back(e);
      @(negedge Clk); #1;
   endtask

   task automatic do_reset();
      @(posedge Clk); #3 Reset = 1'b1;
      #1;
      check("reset_x", int'(BallX), 320);
      check("reset_y", int'(BallY), 240);
      model_reset();
      repeat (2) @(posedge Clk);
      #3 Reset = 1'b0;
   endtask

   task automatic reset_probe(input int dx, input int dy, input int exp);
      DrawX = dx[9:0]; DrawY = dy[9:0];
      #1 check($sformatf("reset_is_ball(%0d,%0d)", dx, dy), int'(is_ball), exp);
   endtask

   // Monitor: a frame rise it observes is a DUT output event that consumes one expectation.
   logic mon_prev, mon_rise;
   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         mon_prev <= 1'b0;
         mon_rise <= 1'b0;
      end else begin
         mon_rise <= frame_clk & ~mon_prev;
         mon_prev <= frame_clk;
      end
   end

   always @(negedge Clk) begin
      pos_t   p;
      probe_t e;
      if (!Reset) begin
         if (mon_rise) begin
            if (pos_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_update: got (%0d,%0d) expected no update", BallX, BallY);
            end else begin
               p = pos_q.pop_front();
               check("ball_x", int'(BallX), p.x);
               check("ball_y", int'(BallY), p.y);
            end
         end
         if (ib_q.size() > 0) begin
            e = ib_q.pop_front();
            check($sformatf("is_ball(%0d,%0d)", e.dx, e.dy), int'(is_ball), e.hit);
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] keys [5];
      keys[0] = 8'h00; keys[1] = 8'h04; keys[2] = 8'h07; keys[3] = 8'h16; keys[4] = 8'h1A;

      Reset = 1'b1; frame_clk = 1'b0; keycode = 8'h00; DrawX = '0; DrawY = '0;
      model_reset();
      repeat (3) @(posedge Clk);
      #3 Reset = 1'b0;
      #1;
      check("init_x", int'(BallX), 320);
      check("init_y", int'(BallY), 240);

      keycode = 8'h07;
      repeat (2) frame(1, 1);

      // Asynchronous reset mid-cycle with the hit test evaluated against the centre.
      @(posedge Clk); #3 Reset = 1'b1;
      #1;
      check("async_reset_x", int'(BallX), 320);
      check("async_reset_y", int'(BallY), 240);
      model_reset();
      reset_probe(320, 240, 1);
      reset_probe(324, 240, 1);
      reset_probe(320, 236, 1);
      reset_probe(325, 240, 0);
      reset_probe(323, 243, 0);
      @(posedge Clk); #3 Reset = 1'b0;

      keycode = 8'h07;
      repeat (3) frame(1, 2);
      frame(100, 2);
      repeat (3) @(posedge Clk);
      #1;
      check("held_high_x", int'(BallX), m_bx);
      check("held_high_value", int'(BallX), 324);

      do_reset();
      keycode = 8'h1A;
      repeat (246) frame(1, 1);
      probe(m_bx, m_by - 4);

      do_reset();
      keycode = 8'h07;
      frame(1, 1);
      keycode = 8'h00;
      repeat (960) frame(1, 1);
      probe(m_bx + 4, m_by);

      do_reset();
      keycode = 8'h04;
      repeat (20) frame(1, 1);
      keycode = 8'h16;
      frame(1, 1);
      keycode = 8'h00;
      repeat (5) frame(2, 1);
      check("a_then_s_x", int'(BallX), 300);

      // Reset while frame_clk is high, released with it still high.
      do_reset();
      keycode = 8'h07;
      repeat (10) frame(1, 1);
      begin
         pos_t p;
         @(posedge Clk); #1;
         model_frame(keycode);
         p.x = m_bx; p.y = m_by;
         pos_q.push_back(p);
         frame_clk = 1'b1;
         repeat (2) @(posedge Clk);
         #3 Reset = 1'b1;
         #1;
         check("reset_high_x", int'(BallX), 320);
         model_reset();
         keycode = 8'h16;
         @(posedge Clk); #3;
         model_frame(keycode);
         p.x = m_bx; p.y = m_by;
         pos_q.push_back(p);
         Reset = 1'b0;
         repeat (3) @(posedge Clk);
         #1 frame_clk = 1'b0;
         check("reset_high_once_y", int'(BallY), 241);
         repeat (2) @(posedge Clk);
      end

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 5) == 5) keycode = 8'($urandom);
         else keycode = keys[$urandom_range(0, 4)];
         frame($urandom_range(1, 4), $urandom_range(1, 3));
         probe(m_bx + $urandom_range(0, 12) - 6, m_by + $urandom_range(0, 12) - 6);
         if (i % 10 == 0) probe($urandom_range(0, 1023), $urandom_range(0, 1023));
      end

      for (int i = 0; i < 20 && (pos_q.size() > 0 || ib_q.size() > 0); i++) @(posedge Clk);
      while (pos_q.size() > 0) begin
         void'(pos_q.pop_front());
         n_cmp++; n_bad++;
         $display("FAIL missing_update: got none expected position update");
      end
      while (ib_q.size() > 0) begin
         void'(ib_q.pop_front());
         n_cmp++; n_bad++;
         $display("FAIL missing_probe: got none expected is_ball sample");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ball_motion.md
Name: ball_motion

Overview:
- Per-frame ball position/motion controller, directly upstream of the colour mapper.
- Updates ball position once per frame from the keyboard keycode, bouncing off screen edges.
- Each pixel clock, compares the VGA scan position (DrawX/DrawY) with the ball to produce is_ball, which the colour mapper consumes combinationally.

Parameters:
- X_CENTER, 320, reset X position
- Y_CENTER, 240, reset Y position
- X_MIN, 0, leftmost legal X
- X_MAX, 639, rightmost legal X
- Y_MIN, 0, topmost legal Y
- Y_MAX, 479, bottommost legal Y
- STEP, 1, pixels moved per frame; must be < SIZE
- SIZE, 4, ball radius in pixels

Ports:
- Clk  input  1  system clock (50 MHz)
- Reset  input  1  reset; asynchronous, active-high
- frame_clk  input  1  frame strobe from VGA controller (VS); asynchronous to nothing, sampled on Clk
- keycode  input  8  current USB HID keycode, 8'h00 = none
- DrawX  input  10  current pixel column
- DrawY  input  10  current pixel row
- is_ball  output  1  current pixel lies inside ball
- BallX  output  10  registered ball centre X
- BallY  output  10  registered ball centre Y

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-high.
- Reset values: BallX=X_CENTER, BallY=Y_CENTER, MotionX=MotionY=0, frame_clk_d=0.
- Frame edge detect: frame_clk_d <= frame_clk every Clk; frame_rise = frame_clk & ~frame_clk_d. Exactly one update per 0->1 transition of frame_clk; a held-high frame_clk gives no further updates.
- Update timing: on the Clk edge where frame_rise=1, MotionX/MotionY <= next motion, and BallX/BallY <= Ball + next motion (the new motion, not the old). Registered outputs change one Clk after frame_clk is first seen high. Otherwise all state holds.
- Motion is 10-bit two's complement; position add is modulo 1024.
- Next-motion priority, Y axis (highest first):
  1. BallY + SIZE >= Y_MAX -> MotionY = -STEP.
  2. BallY <= Y_MIN + SIZE -> MotionY = +STEP.
  3. keycode W (8'h1A) -> MotionY = -STEP, MotionX = 0.
  4. keycode S (8'h16) -> MotionY = +STEP, MotionX = 0.
  5. Otherwise keep.
- Next-motion priority, X axis: same structure with X_MIN/X_MAX. A (8'h04) -> MotionX = -STEP, MotionY = 0; D (8'h07) -> MotionX = +STEP, MotionY = 0.
- A boundary condition on one axis overrides only that axis's value. A key's zeroing of the other axis still applies unless that axis is itself at a boundary.
- Unrecognised keycode (incl. 8'h00): motion unchanged; ball keeps drifting.
- Key held against a wall: the boundary wins on that frame. The next frame the key may reverse again, so the ball dithers within SIZE+STEP of the wall and never leaves [MIN, MAX].
- is_ball is combinational from DrawX, DrawY and the registered BallX/BallY, with zero latency from Draw*:
  - DistX = DrawX - BallX, DistY = DrawY - BallY, both signed 11-bit.
  - is_ball = (DistX² + DistY² <= SIZE²), squares computed at 22 bits signed.
  - Valid during reset using the reset position.
- Reset mid-frame: state returns to centre immediately (asynchronously). The first update after release requires a fresh 0->1 on frame_clk sampled after reset deasserts; frame_clk_d=0 at release, so a frame_clk already high at release counts as a rise.

Decomposition:
- ball_pkg: keycode constants (KEY_W, KEY_A, KEY_S, KEY_D), screen bounds and centre constants, and typedef motion_t (logic signed [9:0]).
- Sub-module rise_detect (Clk, Reset, in, rise) implements the frame_clk edge detector; reusable for other per-frame blocks.
- Motion selection and position update live in ball_motion.

Test Plan:
- Reset asserted asynchronously mid-cycle -> BallX=320, BallY=240 before the next Clk edge; is_ball=1 at (320,240), (324,240) and (320,236); is_ball=0 at (325,240) and (323,243).
- keycode=8'h07, 3 frame_clk pulses -> BallX=321/322/323 after each pulse, BallY=240. frame_clk held high 100 Clk -> only one update.
- keycode=8'h1A held from reset -> BallY decreases by 1 per frame to 4. The next frame flips MotionY to +1 (BallY=5), then dithers between 4 and 5; BallY never < 4.
- keycode=8'h07 for one frame then 8'h00 -> MotionX stays +1. Ball reaches BallX=635, bounces to 634 and continues left unattended to 4, then bounces again.
- keycode=8'h04 then 8'h16 -> after the S frame, MotionX=0, MotionY=+1, and BallX is frozen at its value from the A phase.
- Reset asserted while the ball is at (600,100) with frame_clk high, then deasserted with frame_clk still high -> the first Clk edge after release updates the position once from (320,240) using the current keycode.
